// File: rtl/usb_in_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : usb_in_stream_pkg
//  Purpose  : Shared types and constants for the byte-stream USB IN endpoint
//             packetizer and its byte FIFO.
//  Contents : state_e          - packetizer state encoding
//             MAX_PACKET_LIMIT - largest legal full-speed bulk payload (64)
//             PKT_LEN_W        - width able to hold 0..MAX_PACKET_LIMIT
//             fifo_cnt_width() - occupancy counter width for a given depth
//  Revision : 1.0 - initial release
// ============================================================================
package usb_in_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_FILL     = 3'd2,
        ST_DONE     = 3'd3,
        ST_WAIT_ACK = 3'd4
    } state_e;

    localparam int MAX_PACKET_LIMIT = 64;
    localparam int PKT_LEN_W        = $clog2(MAX_PACKET_LIMIT) + 1;

    // One extra bit over the pointer width so that "full" (count == depth)
    // is representable.
    function automatic int fifo_cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : usb_in_stream_pkg
`default_nettype wire

// File: rtl/usb_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : usb_byte_fifo
//  Purpose  : First-word-fall-through synchronous byte FIFO with an occupancy
//             count. The head byte is valid on data_o whenever empty_o is low.
//  Ports    : clk      - clock
//             reset_n  - asynchronous active-low reset, empties the FIFO
//             push_i   - write request (ignored while full)
//             data_i   - write byte
//             full_o   - FIFO holds DEPTH bytes
//             pop_i    - read request (ignored while empty)
//             data_o   - head byte (fall-through)
//             empty_o  - FIFO holds no bytes
//             count_o  - number of stored bytes, updates the cycle after a
//                        push/pop
//  Params   : DEPTH    - number of entries, power of two
//  Revision : 1.0 - initial release
// ============================================================================
module usb_byte_fifo
    import usb_in_stream_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              push_i,
    input  logic [7:0]                        data_i,
    output logic                              full_o,
    input  logic                              pop_i,
    output logic [7:0]                        data_o,
    output logic                              empty_o,
    output logic [fifo_cnt_width(DEPTH)-1:0]  count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = fifo_cnt_width(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    logic do_push;
    logic do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i  && !empty_o;

    // Pointers are exactly AW bits, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule : usb_byte_fifo
`default_nettype wire

// File: rtl/usb_in_stream_ep.sv
`default_nettype none
// ============================================================================
//  Module   : usb_in_stream_ep
//  Purpose  : Byte-stream to USB bulk IN endpoint packetizer. Buffers user
//             bytes in a local FIFO and hands them to the protocol engine as
//             IN packets of up to MAX_PACKET bytes through the req / grant /
//             put / done / acked handshake. Short packets are sent on a flush
//             request or after FLUSH_FRAMES SOFs with data pending.
//  Ports    : clk             - 48 MHz USB clock
//             reset_n         - asynchronous active-low reset
//             s_data/s_valid  - stream byte in; accepted when s_ready high
//             s_ready         - FIFO not full
//             flush           - pulse: send pending bytes now
//             sof_valid       - SOF pulse from the protocol engine
//             in_ep_req       - buffer request to the protocol engine
//             in_ep_grant     - buffer granted
//             in_ep_data_free - engine buffer has space
//             in_ep_data_put  - byte strobe, in_ep_data valid
//             in_ep_data      - payload byte
//             in_ep_data_done - one-cycle end-of-packet pulse
//             in_ep_stall     - tied low
//             in_ep_acked     - host ACK pulse
//             busy            - packetizer not idle
//  Params   : FIFO_DEPTH (pow2 >= MAX_PACKET), MAX_PACKET (1..64),
//             FLUSH_FRAMES (>= 1)
//  Options  : USB_IN_STREAM_ZLP_EN - send a zero-length packet after a full
//             packet that drained the FIFO, so exact multiples of MAX_PACKET
//             terminate the transfer.
//  Revision : 1.0 - initial release
// ============================================================================
module usb_in_stream_ep
    import usb_in_stream_pkg::*;
#(
    parameter int FIFO_DEPTH   = 64,
    parameter int MAX_PACKET   = 32,
    parameter int FLUSH_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       flush,
    input  logic       sof_valid,
    output logic       in_ep_req,
    input  logic       in_ep_grant,
    input  logic       in_ep_data_free,
    output logic       in_ep_data_put,
    output logic [7:0] in_ep_data,
    output logic       in_ep_data_done,
    output logic       in_ep_stall,
    input  logic       in_ep_acked,
    output logic       busy
);

    localparam int CW  = fifo_cnt_width(FIFO_DEPTH);
    localparam int FCW = $clog2(FLUSH_FRAMES + 1);

    localparam logic [CW-1:0]        MAX_PKT_CNT = CW'(MAX_PACKET);
    localparam logic [PKT_LEN_W-1:0] MAX_PKT_LEN = PKT_LEN_W'(MAX_PACKET);
    localparam logic [FCW-1:0]       FLUSH_LIMIT = FCW'(FLUSH_FRAMES);

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic          fifo_pop;

    usb_byte_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (s_valid),
        .data_i  (s_data),
        .full_o  (fifo_full),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign s_ready = !fifo_full;

    // ------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------
    state_e                 state_q;
    logic                   req_q;
    logic                   put_q;
    logic [7:0]             data_q;
    logic                   done_q;
    logic [PKT_LEN_W-1:0]   pkt_len_q;
    logic [PKT_LEN_W-1:0]   pkt_cnt_q;

    logic                   flush_pending_q;
    logic                   flush_pending_d;
    logic [FCW-1:0]         frame_cnt_q;
    logic [FCW-1:0]         frame_cnt_d;

    logic                   launch;
    logic                   zlp_launch;
    logic [PKT_LEN_W-1:0]   launch_len;

    // ------------------------------------------------------------------
    // Zero-length packet termination (optional)
    // ------------------------------------------------------------------
`ifdef USB_IN_STREAM_ZLP_EN
    logic zlp_pending_q;
    logic zlp_pending_d;

    assign zlp_launch = zlp_pending_q && fifo_empty;

    always_comb begin
        zlp_pending_d = zlp_pending_q;
        if (launch) begin
            zlp_pending_d = 1'b0;
        end else if ((state_q == ST_WAIT_ACK) && in_ep_acked &&
                     (pkt_len_q == MAX_PKT_LEN) && fifo_empty) begin
            zlp_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            zlp_pending_q <= 1'b0;
        end else begin
            zlp_pending_q <= zlp_pending_d;
        end
    end
`else
    assign zlp_launch = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Launch decision. A flush arriving in the launch cycle counts
    // directly, so a flush on a non-empty idle FIFO requests the buffer on
    // the very next cycle.
    // ------------------------------------------------------------------
    always_comb begin
        launch = 1'b0;
        if (state_q == ST_IDLE) begin
            if (fifo_count >= MAX_PKT_CNT) begin
                launch = 1'b1;
            end else if (!fifo_empty &&
                         (flush || flush_pending_q || (frame_cnt_q == FLUSH_LIMIT))) begin
                launch = 1'b1;
            end else if (zlp_launch) begin
                launch = 1'b1;
            end
        end
    end

    // Below MAX_PACKET the count always fits the packet length field.
    assign launch_len = (fifo_count >= MAX_PKT_CNT) ? MAX_PKT_LEN
                                                    : PKT_LEN_W'(fifo_count);

    assign fifo_pop = (state_q == ST_FILL) && in_ep_grant && in_ep_data_free &&
                      (pkt_cnt_q < pkt_len_q);

    // Pending-flush and SOF idle counters; a launch absorbs any flush or SOF
    // seen in the same cycle.
    always_comb begin
        flush_pending_d = flush_pending_q;
        if (launch) begin
            flush_pending_d = 1'b0;
        end else if (flush && !fifo_empty) begin
            flush_pending_d = 1'b1;
        end

        frame_cnt_d = frame_cnt_q;
        if (launch || fifo_empty) begin
            frame_cnt_d = '0;
        end else if (sof_valid && (state_q == ST_IDLE) && (frame_cnt_q != FLUSH_LIMIT)) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flush_pending_q <= 1'b0;
            frame_cnt_q     <= '0;
        end else begin
            flush_pending_q <= flush_pending_d;
            frame_cnt_q     <= frame_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Packetizer FSM with registered handshake outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            put_q     <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
            pkt_len_q <= '0;
            pkt_cnt_q <= '0;
        end else begin
            put_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (launch) begin
                        state_q   <= ST_REQ;
                        req_q     <= 1'b1;
                        pkt_len_q <= launch_len;
                        pkt_cnt_q <= '0;
                    end
                end
                ST_REQ: begin
                    // A zero-length packet has nothing to fill.
                    if (in_ep_grant) begin
                        state_q <= (pkt_len_q == '0) ? ST_DONE : ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (fifo_pop) begin
                        put_q     <= 1'b1;
                        data_q    <= fifo_head;
                        pkt_cnt_q <= pkt_cnt_q + 1'b1;
                        // Leaving on the last put makes done follow it by
                        // exactly one cycle.
                        if ((pkt_cnt_q + 1'b1) == pkt_len_q) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (in_ep_acked) begin
                        state_q <= ST_IDLE;
                        req_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ep_req       = req_q;
    assign in_ep_data_put  = put_q;
    assign in_ep_data      = data_q;
    assign in_ep_data_done = done_q;
    assign in_ep_stall     = 1'b0;
    assign busy            = (state_q != ST_IDLE);

endmodule : usb_in_stream_ep
`default_nettype wire
